// File: rtl/pedal_actuator_pkg.sv
// Shared encodings and constants for the pedal actuator: FSM states, PWM width,
// buzzer pattern timing and saturating duty helpers.
package pedal_actuator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GAZ  = 2'b01,
    DEAD = 2'b11,
    FREN = 2'b10
  } pedal_state_t;

  localparam int PWM_W = 8;
  localparam int DUTY_MAX = (1 << PWM_W) - 1;

  localparam int BUZ_PERIOD   = 500;
  localparam int BUZ_YAYA_ON  = 250;
  localparam int BUZ_TAKIP_ON = 100;
  localparam int BUZ_CW       = $clog2(BUZ_PERIOD);

  // Duty arithmetic is done in int so a large step can never wrap before clamping.
  function automatic logic [PWM_W-1:0] sat_add(input logic [PWM_W-1:0] a, input int step);
    int s;
    s = int'(a) + step;
    return (s > DUTY_MAX) ? PWM_W'(DUTY_MAX) : PWM_W'(s);
  endfunction

  function automatic logic [PWM_W-1:0] sat_sub(input logic [PWM_W-1:0] a, input int step);
    int s;
    s = int'(a) - step;
    return (s < 0) ? '0 : PWM_W'(s);
  endfunction

endpackage

// File: rtl/uyari_buzzer.sv
// Driver warning buzzer: a tick-paced 500-step pattern counter, parked at 0
// while no warning is active, gated by the highest-priority active warning.
module uyari_buzzer
  import pedal_actuator_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic kirmizi_isik_i,
  input  logic yaya_gecidi_i,
  input  logic takip_mesafe_i,
  output logic buzzer_o
);

  logic [BUZ_CW-1:0] pat_cnt;
  logic              any_warn;
  logic              buz_d;

  assign any_warn = kirmizi_isik_i | yaya_gecidi_i | takip_mesafe_i;

  always_comb begin
    buz_d = 1'b0;
    if (kirmizi_isik_i)      buz_d = 1'b1;
    else if (yaya_gecidi_i)  buz_d = (pat_cnt < BUZ_CW'(BUZ_YAYA_ON));
    else if (takip_mesafe_i) buz_d = (pat_cnt < BUZ_CW'(BUZ_TAKIP_ON));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_cnt  <= '0;
      buzzer_o <= 1'b0;
    end else begin
      buzzer_o <= buz_d;
      if (!any_warn)
        pat_cnt <= '0;
      else if (tick_i)
        pat_cnt <= (pat_cnt == BUZ_CW'(BUZ_PERIOD - 1)) ? '0 : pat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pedal_actuator.sv
// Throttle/brake actuator: mutually exclusive duty ramps with a dead-time gap
// between pedals, registered PWM drive and the warning buzzer.
module pedal_actuator
  import pedal_actuator_pkg::*;
#(
  parameter int RAMP_STEP   = 8,
  parameter int DEADTIME_MS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_tick_i,
  input  logic             gaz_i,
  input  logic             fren_i,
  input  logic             kirmizi_isik_i,
  input  logic             yaya_gecidi_i,
  input  logic             takip_mesafe_i,
  output logic [PWM_W-1:0] gaz_duty_o,
  output logic [PWM_W-1:0] fren_duty_o,
  output logic             gaz_pwm_o,
  output logic             fren_pwm_o,
  output logic             buzzer_o
);

  localparam int DW = (DEADTIME_MS < 2) ? 1 : $clog2(DEADTIME_MS + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME_MS);

  pedal_state_t     state_q, state_d;
  logic [PWM_W-1:0] gaz_duty_q, gaz_d;
  logic [PWM_W-1:0] fren_duty_q, fren_d;
  logic [DW-1:0]    dead_cnt_q, dead_d;
  logic [PWM_W-1:0] pwm_cnt;

  always_comb begin
    state_d = state_q;
    gaz_d   = gaz_duty_q;
    fren_d  = fren_duty_q;
    dead_d  = dead_cnt_q;
    case (state_q)
      IDLE: begin
        gaz_d  = '0;
        fren_d = '0;
        if (fren_i)     state_d = FREN;
        else if (gaz_i) state_d = GAZ;
      end
      GAZ: begin
        fren_d = '0;
        // Brake request kills throttle immediately, without waiting for a tick.
        if (fren_i) begin
          gaz_d   = '0;
          dead_d  = DEAD_LOAD;
          state_d = DEAD;
        end else if (!gaz_i && gaz_duty_q == '0) begin
          state_d = IDLE;
        end else if (timer_tick_i) begin
          gaz_d = gaz_i ? sat_add(gaz_duty_q, RAMP_STEP) : sat_sub(gaz_duty_q, RAMP_STEP);
        end
      end
      DEAD: begin
        gaz_d  = '0;
        fren_d = '0;
        if (timer_tick_i) begin
          if (dead_cnt_q <= DW'(1)) begin
            dead_d = '0;
            if (fren_i)     state_d = FREN;
            else if (gaz_i) state_d = GAZ;
            else            state_d = IDLE;
          end else begin
            dead_d = dead_cnt_q - 1'b1;
          end
        end
      end
      FREN: begin
        gaz_d = '0;
        if (!fren_i && fren_duty_q == '0) begin
          dead_d  = DEAD_LOAD;
          state_d = DEAD;
        end else if (timer_tick_i) begin
          fren_d = fren_i ? sat_add(fren_duty_q, 2 * RAMP_STEP) : sat_sub(fren_duty_q, RAMP_STEP);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gaz_duty_q  <= '0;
      fren_duty_q <= '0;
      dead_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gaz_duty_q  <= gaz_d;
      fren_duty_q <= fren_d;
      dead_cnt_q  <= dead_d;
    end
  end

  // Only one duty can be nonzero at a time, so the two compares never fire together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt    <= '0;
      gaz_pwm_o  <= 1'b0;
      fren_pwm_o <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      gaz_pwm_o  <= (pwm_cnt < gaz_duty_q);
      fren_pwm_o <= (pwm_cnt < fren_duty_q);
    end
  end

  assign gaz_duty_o  = gaz_duty_q;
  assign fren_duty_o = fren_duty_q;

  uyari_buzzer u_buzzer (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick_i         (timer_tick_i),
    .kirmizi_isik_i (kirmizi_isik_i),
    .yaya_gecidi_i  (yaya_gecidi_i),
    .takip_mesafe_i (takip_mesafe_i),
    .buzzer_o       (buzzer_o)
  );

endmodule

// File: tb/tb_pedal_actuator.sv
// Bench for pedal_actuator: directed scenarios plus randomized traffic, every
// cycle scored against a behavioural model of the pedal/buzzer rules.
module tb_pedal_actuator;

  localparam int RS = 8;
  localparam int DT = 3;
  localparam int M_IDLE = 0, M_GAZ = 1, M_DEAD = 2, M_FREN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, gaz = 1'b0, fren = 1'b0;
  logic       kir = 1'b0, yaya = 1'b0, takip = 1'b0;
  logic [7:0] gaz_duty, fren_duty;
  logic       gaz_pwm, fren_pwm, buzzer;

  int errs = 0;
  int checks = 0;

  // Reference model state
  int m_st = M_IDLE, m_gd = 0, m_fd = 0, m_dc = 0;
  int m_pc = 0, m_gp = 0, m_fp = 0, m_bc = 0, m_bz = 0;

  pedal_actuator #(.RAMP_STEP(RS), .DEADTIME_MS(DT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .timer_tick_i   (tick),
    .gaz_i          (gaz),
    .fren_i         (fren),
    .kirmizi_isik_i (kir),
    .yaya_gecidi_i  (yaya),
    .takip_mesafe_i (takip),
    .gaz_duty_o     (gaz_duty),
    .fren_duty_o    (fren_duty),
    .gaz_pwm_o      (gaz_pwm),
    .fren_pwm_o     (fren_pwm),
    .buzzer_o       (buzzer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One clock edge of the pedal/buzzer rules, using the values before the edge.
  task automatic model_step();
    bit go_idle, go_dead;
    if (!rst_n) begin
      m_st = M_IDLE; m_gd = 0; m_fd = 0; m_dc = 0;
      m_pc = 0; m_gp = 0; m_fp = 0; m_bc = 0; m_bz = 0;
      return;
    end
    m_gp = (m_pc < m_gd) ? 1 : 0;
    m_fp = (m_pc < m_fd) ? 1 : 0;
    m_pc = (m_pc + 1) % 256;
    if (kir)        m_bz = 1;
    else if (yaya)  m_bz = (m_bc < 250) ? 1 : 0;
    else if (takip) m_bz = (m_bc < 100) ? 1 : 0;
    else            m_bz = 0;
    if (!(kir || yaya || takip)) m_bc = 0;
    else if (tick)               m_bc = (m_bc + 1) % 500;
    case (m_st)
      M_IDLE: begin
        if (fren)     m_st = M_FREN;
        else if (gaz) m_st = M_GAZ;
      end
      M_GAZ: begin
        go_idle = !gaz && m_gd == 0;
        if (fren) begin
          m_gd = 0; m_dc = DT; m_st = M_DEAD;
        end else if (go_idle) begin
          m_st = M_IDLE;
        end else if (tick) begin
          m_gd = gaz ? imin(m_gd + RS, 255) : imax(m_gd - RS, 0);
        end
      end
      M_DEAD: begin
        if (tick) begin
          if (m_dc <= 1) begin
            m_dc = 0;
            m_st = fren ? M_FREN : (gaz ? M_GAZ : M_IDLE);
          end else begin
            m_dc--;
          end
        end
      end
      default: begin
        go_dead = !fren && m_fd == 0;
        if (go_dead) begin
          m_dc = DT; m_st = M_DEAD;
        end else if (tick) begin
          m_fd = fren ? imin(m_fd + 2 * RS, 255) : imax(m_fd - RS, 0);
        end
      end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("gaz_duty", int'(gaz_duty), m_gd);
    chk("fren_duty", int'(fren_duty), m_fd);
    chk("gaz_pwm", int'(gaz_pwm), m_gp);
    chk("fren_pwm", int'(fren_pwm), m_fp);
    chk("buzzer", int'(buzzer), m_bz);
    chk("duty_excl", (gaz_duty != 0 && fren_duty != 0) ? 1 : 0, 0);
    chk("pwm_excl", (gaz_pwm && fren_pwm) ? 1 : 0, 0);
  endtask

  task automatic tick1();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
  endtask

  task automatic do_rst();
    rst_n = 1'b0; tick = 1'b0; gaz = 1'b0; fren = 1'b0;
    kir = 1'b0; yaya = 1'b0; takip = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int hi, lo;

    // Reset state
    do_rst();
    chk("rst_gd", int'(gaz_duty), 0);
    chk("rst_fd", int'(fren_duty), 0);
    chk("rst_gp", int'(gaz_pwm), 0);
    chk("rst_bz", int'(buzzer), 0);

    // Throttle ramp to saturation
    gaz = 1'b1; cyc();
    for (int i = 1; i <= 40; i++) begin
      tick1();
      chk("ramp_gd", int'(gaz_duty), (i * 8 > 255) ? 255 : i * 8);
      chk("ramp_fd", int'(fren_duty), 0);
    end

    // Throttle at 80, brake between ticks: dead time then brake ramp
    do_rst();
    gaz = 1'b1; cyc();
    repeat (10) tick1();
    chk("pre_kill", int'(gaz_duty), 80);
    fren = 1'b1; cyc();
    chk("kill_gd", int'(gaz_duty), 0);
    for (int i = 1; i <= 3; i++) begin
      tick1();
      chk("dead_fd", int'(fren_duty), 0);
      chk("dead_gd", int'(gaz_duty), 0);
    end
    for (int i = 1; i <= 16; i++) begin
      tick1();
      chk("fren_ramp", int'(fren_duty), (i * 16 > 255) ? 255 : i * 16);
    end

    // Both pedals from IDLE: brake straight away, throttle PWM silent
    do_rst();
    gaz = 1'b1; fren = 1'b1; cyc();
    repeat (5) tick1();
    chk("both_fd", int'(fren_duty), 80);
    chk("both_gd", int'(gaz_duty), 0);
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (gaz_pwm) hi++;
    end
    chk("both_gpwm", hi, 0);

    // Throttle held at 64: exact PWM duty over 256 clocks
    do_rst();
    gaz = 1'b1; cyc();
    repeat (8) tick1();
    chk("hold_gd", int'(gaz_duty), 64);
    cyc();
    hi = 0; lo = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (gaz_pwm) hi++;
      if (fren_pwm) lo++;
    end
    chk("pwm64_hi", hi, 64);
    chk("pwm64_fren", lo, 0);

    // Reset in FREN at 128, then IDLE reaches GAZ with no dead time
    do_rst();
    fren = 1'b1; cyc();
    repeat (8) tick1();
    chk("pre_rst_fd", int'(fren_duty), 128);
    rst_n = 1'b0; cyc();
    chk("mid_rst_fd", int'(fren_duty), 0);
    chk("mid_rst_fp", int'(fren_pwm), 0);
    chk("mid_rst_bz", int'(buzzer), 0);
    rst_n = 1'b1; fren = 1'b0; gaz = 1'b1; cyc();
    tick1();
    chk("post_rst_gd", int'(gaz_duty), 8);

    // Pedestrian pattern, then red light overrides
    do_rst();
    yaya = 1'b1; cyc();
    for (int j = 1; j <= 1000; j++) begin
      tick = 1'b1; cyc();
      chk("yaya_bz", int'(buzzer), (((j - 1) % 500) < 250) ? 1 : 0);
      tick = 1'b0; cyc();
    end
    kir = 1'b1; cyc();
    for (int j = 0; j < 600; j++) begin
      tick1();
      chk("kir_bz", int'(buzzer), 1);
    end

    // Following-distance pattern
    do_rst();
    takip = 1'b1; cyc();
    hi = 0;
    for (int j = 0; j < 500; j++) begin
      tick = 1'b1; cyc();
      if (buzzer) hi++;
      tick = 1'b0; cyc();
    end
    chk("takip_hi", hi, 100);

    // Randomized traffic scored by the model every clock
    do_rst();
    for (int n = 0; n < 20000; n++) begin
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0)  gaz   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0)  fren  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) kir   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) yaya  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) takip = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 2999) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pedal_actuator.md
PEDAL_ACTUATOR -- requirements
Module: pedal_actuator

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 8, meaning the throttle duty increment/decrement per timer tick (brake rises at 2*RAMP_STEP).
REQ-002 SHALL have parameter DEADTIME_MS, default 3, meaning the ticks both actuators are held off when switching between throttle and brake.
REQ-003 clk  in  1  system clock, single clock domain.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 timer_tick_i  in  1  one-clock pulse every 1 ms.
REQ-006 gaz_i  in  1  throttle request from the ADAS control FSM.
REQ-007 fren_i  in  1  brake request from the ADAS control FSM.
REQ-008 kirmizi_isik_i  in  1  red-light warning.
REQ-009 yaya_gecidi_i  in  1  pedestrian-crossing warning.
REQ-010 takip_mesafe_i  in  1  following-distance warning.
REQ-011 gaz_duty_o  out  8  current throttle duty, 0..255.
REQ-012 fren_duty_o  out  8  current brake duty, 0..255.
REQ-013 gaz_pwm_o  out  1  throttle PWM drive.
REQ-014 fren_pwm_o  out  1  brake PWM drive.
REQ-015 buzzer_o  out  1  driver warning buzzer.

Function
REQ-016 SHALL implement FSM states IDLE=2'b00, GAZ=2'b01, DEAD=2'b11, FREN=2'b10 (Gray); transitions are evaluated every clock, duty changes only on timer_tick_i unless stated.
REQ-017 IDLE: both duties 0; fren_i=1 -> FREN (brake has priority, no dead time from IDLE); else gaz_i=1 -> GAZ.
REQ-018 GAZ, on tick: gaz_i=1 -> gaz_duty saturating +RAMP_STEP (cap 255); gaz_i=0 -> saturating -RAMP_STEP (floor 0).
REQ-019 GAZ: gaz_i=0 and gaz_duty=0 -> IDLE.
REQ-020 GAZ: fren_i=1 -> on that same clock edge, regardless of tick, gaz_duty <= 0, dead counter <= DEADTIME_MS, -> DEAD.
REQ-021 DEAD: both duties 0; counter decrements on each tick; on the tick at which the counter reads 1 -> FREN if fren_i, else GAZ if gaz_i, else IDLE.
REQ-022 FREN, on tick: fren_i=1 -> fren_duty saturating +2*RAMP_STEP; fren_i=0 -> saturating -RAMP_STEP; gaz_i is ignored.
REQ-023 FREN: fren_i=0 and fren_duty=0 -> load dead counter, -> DEAD (dead time also applies brake-to-throttle).
REQ-024 gaz_i=1 and fren_i=1 simultaneously: brake wins in every state.
REQ-025 gaz_duty_o and fren_duty_o SHALL never both be nonzero.
REQ-026 PWM: free-running 8-bit counter incremented every clk; gaz_pwm_o registered = (cnt < gaz_duty); fren_pwm_o likewise; one clock latency; duty 0 gives constant 0, duty 255 gives 255/256.
REQ-027 gaz_pwm_o and fren_pwm_o SHALL never both be 1.
REQ-028 Buzzer: pattern counter 0..499 advances on tick and wraps; it is held at 0 while no warning is active.
REQ-029 Buzzer priority: kirmizi_isik_i -> buzzer_o constantly 1; else yaya_gecidi_i -> 1 while counter <250; else takip_mesafe_i -> 1 while counter <100; else 0. buzzer_o is registered.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force state IDLE, both duties 0, both PWM outputs 0, buzzer_o 0, and all counters 0, including mid-ramp or mid-DEAD.
REQ-031 The first tick after reset is released SHALL be treated as a normal tick.

Structure
REQ-032 pedal_actuator_pkg SHALL hold the state encodings, the PWM width (8), and the buzzer constants (period 500, yaya on 250, takip on 100).
REQ-033 The buzzer pattern logic SHALL be one sub-module, uyari_buzzer; the FSM, ramps and PWM stay in pedal_actuator.

Verification
REQ-034 Reset, gaz_i=1 for 40 ticks -> gaz_duty_o = 8,16,...,248, then 255 from tick 32 on; fren_duty_o stays 0.
REQ-035 gaz_duty=80, fren_i=1 raised between ticks -> gaz_duty_o=0 at the next edge, DEAD for 3 ticks, then FREN, fren_duty_o +16 per tick reaching 255 at tick 16.
REQ-036 IDLE, gaz_i=fren_i=1 -> FREN directly, gaz_duty_o stays 0, gaz_pwm_o never 1.
REQ-037 gaz_duty held at 64 -> gaz_pwm_o high for exactly 64 of every 256 clocks; fren_pwm_o stays 0.
REQ-038 yaya_gecidi_i only -> buzzer_o high 250 ticks then low 250 ticks, repeating; kirmizi_isik_i added -> buzzer_o constantly 1.
REQ-039 In FREN with fren_duty=128, rst_n low for 1 clock -> next edge all outputs 0, state IDLE.
